// File: rtl/timer_seq_master.sv
// ============================================================================
// Module   : timer_seq_master
// Function : Avalon-MM master that programs a 16-bit interval timer and
//            services its timeout interrupts with a snapshot read-back.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module timer_seq_master #(
    parameter int          MIN_PERIOD = 2,
    parameter logic [31:0] WDOG_MAX   = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_start,
    input  logic        cmd_stop,
    input  logic [31:0] cmd_period,
    input  logic        cmd_continuous,
    output logic        busy,
    output logic        cmd_err,
    output logic        snap_valid,
    output logic [31:0] snap_value,
    output logic [15:0] timeout_count,
    output logic        wdog_err,
    output logic [2:0]  address,
    output logic        chipselect,
    output logic        write_n,
    output logic [15:0] writedata,
    input  logic [15:0] readdata,
    input  logic        irq
);

    localparam logic [31:0] c_min_period = 32'(MIN_PERIOD);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_W_STOP   = 4'd1,
        S_W_PL     = 4'd2,
        S_W_PH     = 4'd3,
        S_W_CTRL   = 4'd4,
        S_WAIT_IRQ = 4'd5,
        S_W_CLR    = 4'd6,
        S_W_SNAP   = 4'd7,
        S_R_SL     = 4'd8,
        S_R_SH     = 4'd9,
        S_CAP      = 4'd10,
        S_W_HALT   = 4'd11
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_period;
    logic        r_cont;
    logic        r_stop_pend;
    logic [31:0] r_wdog_cnt;
    logic        r_wdog_err;
    logic        r_cmd_err;
    logic        r_snap_valid;
    logic [31:0] r_snap_value;
    logic [15:0] r_timeout_count;

    logic        w_accept;
    logic        w_reject;
    logic        w_wdog_set;
    logic [32:0] w_wdog_sum;
    logic [31:0] w_wdog_limit;
    logic [31:0] w_wdog_inc;
    logic        w_wdog_trip;

    // Limit saturates so a huge period plus WDOG_MAX cannot wrap to a small value.
    assign w_wdog_sum   = {1'b0, r_period} + {1'b0, WDOG_MAX};
    assign w_wdog_limit = w_wdog_sum[32] ? 32'hFFFF_FFFF : w_wdog_sum[31:0];
    assign w_wdog_inc   = r_wdog_cnt + 32'd1;
    assign w_wdog_trip  = (w_wdog_inc == w_wdog_limit);

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_reject     = 1'b0;
        w_wdog_set   = 1'b0;
        address      = 3'd0;
        chipselect   = 1'b0;
        write_n      = 1'b1;
        writedata    = 16'h0000;
        case (r_state)
            S_IDLE: begin
                if (cmd_start && !cmd_stop) begin
                    if (cmd_period < c_min_period) begin
                        w_reject = 1'b1;
                    end else begin
                        w_accept     = 1'b1;
                        w_next_state = S_W_STOP;
                    end
                end
            end
            S_W_STOP: begin
                chipselect   = 1'b1;
                write_n      = 1'b0;
                address      = 3'd1;
                writedata    = 16'h0008;
                w_next_state = S_W_PL;
            end
            S_W_PL: begin
                chipselect   = 1'b1;
                write_n      = 1'b0;
                address      = 3'd2;
                writedata    = r_period[15:0];
                w_next_state = S_W_PH;
            end
            S_W_PH: begin
                chipselect   = 1'b1;
                write_n      = 1'b0;
                address      = 3'd3;
                writedata    = r_period[31:16];
                w_next_state = S_W_CTRL;
            end
            S_W_CTRL: begin
                chipselect   = 1'b1;
                write_n      = 1'b0;
                address      = 3'd1;
                writedata    = {12'h000, 1'b0, 1'b1, r_cont, 1'b1};
                w_next_state = S_WAIT_IRQ;
            end
            S_WAIT_IRQ: begin
                if (r_stop_pend || cmd_stop) begin
                    w_next_state = S_W_HALT;
                end else if (irq) begin
                    w_next_state = S_W_CLR;
                end else if (w_wdog_trip) begin
                    w_wdog_set   = 1'b1;
                    w_next_state = S_W_HALT;
                end
            end
            S_W_CLR: begin
                chipselect   = 1'b1;
                write_n      = 1'b0;
                address      = 3'd0;
                w_next_state = S_W_SNAP;
            end
            S_W_SNAP: begin
                chipselect   = 1'b1;
                write_n      = 1'b0;
                address      = 3'd4;
                w_next_state = S_R_SL;
            end
            S_R_SL: begin
                chipselect   = 1'b1;
                address      = 3'd4;
                w_next_state = S_R_SH;
            end
            S_R_SH: begin
                chipselect   = 1'b1;
                address      = 3'd5;
                w_next_state = S_CAP;
            end
            S_CAP: begin
                // irq is only looked at again from WAIT_IRQ, after the slave's
                // registered deassertion has had time to settle.
                if (r_cont && !r_stop_pend && !cmd_stop) begin
                    w_next_state = S_WAIT_IRQ;
                end else begin
                    w_next_state = S_W_HALT;
                end
            end
            S_W_HALT: begin
                chipselect   = 1'b1;
                write_n      = 1'b0;
                address      = 3'd1;
                writedata    = 16'h0008;
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= S_IDLE;
            r_period        <= 32'd0;
            r_cont          <= 1'b0;
            r_stop_pend     <= 1'b0;
            r_wdog_cnt      <= 32'd0;
            r_wdog_err      <= 1'b0;
            r_cmd_err       <= 1'b0;
            r_snap_valid    <= 1'b0;
            r_snap_value    <= 32'd0;
            r_timeout_count <= 16'd0;
        end else begin
            r_state      <= w_next_state;
            r_cmd_err    <= w_reject;
            r_snap_valid <= (r_state == S_CAP);

            if (w_accept) begin
                r_period   <= cmd_period;
                r_cont     <= cmd_continuous;
                r_wdog_err <= 1'b0;
            end else if (w_wdog_set) begin
                r_wdog_err <= 1'b1;
            end

            if (r_state == S_W_CTRL || r_state == S_CAP) begin
                r_wdog_cnt <= 32'd0;
            end else if (r_state == S_WAIT_IRQ) begin
                r_wdog_cnt <= w_wdog_inc;
            end

            // A stop outside WAIT_IRQ is deferred until the sequence completes.
            if (r_state == S_W_HALT) begin
                r_stop_pend <= 1'b0;
            end else if (cmd_stop && r_state != S_IDLE && r_state != S_WAIT_IRQ) begin
                r_stop_pend <= 1'b1;
            end

            if (r_state == S_W_CLR) begin
                r_timeout_count <= r_timeout_count + 16'd1;
            end
            if (r_state == S_R_SH) begin
                r_snap_value[15:0] <= readdata;
            end
            if (r_state == S_CAP) begin
                r_snap_value[31:16] <= readdata;
            end
        end
    end

    assign busy          = (r_state != S_IDLE);
    assign cmd_err       = r_cmd_err;
    assign snap_valid    = r_snap_valid;
    assign snap_value    = r_snap_value;
    assign timeout_count = r_timeout_count;
    assign wdog_err      = r_wdog_err;

endmodule

`default_nettype wire

// File: tb/tb_timer_seq_master.sv
// ============================================================================
// Module   : tb_timer_seq_master
// Function : Self-checking bench for timer_seq_master with an interval-timer
//            slave model and bus/snapshot scoreboards.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_timer_seq_master;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_start = 1'b0;
    logic        cmd_stop = 1'b0;
    logic [31:0] cmd_period = 32'd0;
    logic        cmd_continuous = 1'b0;
    logic        busy;
    logic        cmd_err;
    logic        snap_valid;
    logic [31:0] snap_value;
    logic [15:0] timeout_count;
    logic        wdog_err;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata = 16'h0;
    logic        irq;

    timer_seq_master #(
        .MIN_PERIOD (2),
        .WDOG_MAX   (32'd10)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .cmd_start      (cmd_start),
        .cmd_stop       (cmd_stop),
        .cmd_period     (cmd_period),
        .cmd_continuous (cmd_continuous),
        .busy           (busy),
        .cmd_err        (cmd_err),
        .snap_valid     (snap_valid),
        .snap_value     (snap_value),
        .timeout_count  (timeout_count),
        .wdog_err       (wdog_err),
        .address        (address),
        .chipselect     (chipselect),
        .write_n        (write_n),
        .writedata      (writedata),
        .readdata       (readdata),
        .irq            (irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- scoreboards: {read, addr, data} bus ops and snapshots
    logic [19:0] bus_q[$];
    logic [31:0] snap_q[$];

    function automatic logic [19:0] bw(input logic [2:0] a, input logic [15:0] d);
        return {1'b0, a, d};
    endfunction
    function automatic logic [19:0] br(input logic [2:0] a);
        return {1'b1, a, 16'h0000};
    endfunction

    task automatic push_prog(input logic [31:0] p, input logic c);
        bus_q.push_back(bw(3'd1, 16'h0008));
        bus_q.push_back(bw(3'd2, p[15:0]));
        bus_q.push_back(bw(3'd3, p[31:16]));
        bus_q.push_back(bw(3'd1, {12'h000, 1'b0, 1'b1, c, 1'b1}));
    endtask
    task automatic push_service();
        bus_q.push_back(bw(3'd0, 16'h0000));
        bus_q.push_back(bw(3'd4, 16'h0000));
        bus_q.push_back(br(3'd4));
        bus_q.push_back(br(3'd5));
    endtask

    // ---------------- interval timer slave model
    logic [15:0] m_pl = 16'h0, m_ph = 16'h0;
    logic        m_run = 1'b0, m_cont = 1'b0, m_ito = 1'b0, m_to = 1'b0;
    logic [31:0] m_cnt = 32'h0, m_snap = 32'h0;
    logic        m_mute = 1'b0;
    logic        kick_req = 1'b0;

    assign irq = m_to & m_ito;

    always @(posedge clk) begin
        readdata <= 16'h0000;
        if (m_run) begin
            if (m_cnt == 32'd0) begin
                if (!m_mute) begin
                    if (m_ito && !m_to) push_service();
                    m_to <= 1'b1;
                end
                if (m_cont) m_cnt <= {m_ph, m_pl};
                else        m_run <= 1'b0;
            end else begin
                m_cnt <= m_cnt - 32'd1;
            end
        end
        if (kick_req) m_to <= 1'b1;
        if (chipselect && !write_n) begin
            case (address)
                3'd0: m_to <= 1'b0;
                3'd1: begin
                    m_ito  <= writedata[0];
                    m_cont <= writedata[1];
                    if (writedata[2]) begin
                        m_run <= 1'b1;
                        m_cnt <= {m_ph, m_pl};
                    end
                    if (writedata[3]) m_run <= 1'b0;
                end
                3'd2: m_pl <= writedata;
                3'd3: m_ph <= writedata;
                3'd4: begin
                    m_snap <= m_cnt;
                    snap_q.push_back(m_cnt);
                end
                default: ;
            endcase
        end else if (chipselect && write_n) begin
            if (address == 3'd4) readdata <= m_snap[15:0];
            if (address == 3'd5) readdata <= m_snap[31:16];
        end
    end

    // ---------------- monitor
    int   ctrl_cyc = 0, w8_cyc = 0, snap_cyc = 0, snap_cnt = 0, irq_cyc = 0;
    logic irq_d = 1'b0;

    initial begin
        logic [19:0] got;
        forever begin
            @(negedge clk);
            if (reset_n && chipselect) begin
                got = {write_n, address, (write_n ? 16'h0000 : writedata)};
                if (bus_q.size() == 0) check_eq("bus_extra", bus_q.size(), 1);
                else check_eq("bus", {12'h0, got}, {12'h0, bus_q.pop_front()});
                if (!write_n && address == 3'd1) begin
                    if (writedata[2]) ctrl_cyc = cyc;
                    if (writedata == 16'h0008) w8_cyc = cyc;
                end
            end
            if (snap_valid) begin
                snap_cyc = cyc;
                snap_cnt++;
                if (snap_q.size() == 0) check_eq("snap_extra", snap_q.size(), 1);
                else check_eq("snap", snap_value, snap_q.pop_front());
                check_eq("irq2snap", cyc - irq_cyc, 6);
            end
            if (irq && !irq_d) irq_cyc = cyc;
            irq_d = irq;
        end
    end

    // ---------------- stimulus helpers
    task automatic do_cmd(input logic s, input logic t, input logic [31:0] p, input logic c,
                          output int sc);
        @(negedge clk);
        sc = cyc;
        cmd_start = s; cmd_stop = t; cmd_period = p; cmd_continuous = c;
        @(negedge clk);
        cmd_start = 1'b0; cmd_stop = 1'b0;
    endtask

    task automatic irq_kick(input logic halt);
        @(negedge clk);
        push_service();
        if (halt) bus_q.push_back(bw(3'd1, 16'h0008));
        kick_req = 1'b1;
        @(negedge clk);
        kick_req = 1'b0;
    endtask

    task automatic wait_snap(input int bound, output int at);
        int  c0;
        bit  seen;
        c0 = snap_cnt;
        seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clk);
            if (snap_cnt != c0) seen = 1'b1;
        end
        if (!seen) check_eq("snap_wait", snap_cnt, c0 + 1);
        at = snap_cyc;
    endtask

    task automatic wait_idle(input int bound);
        bit done;
        done = 1'b0;
        for (int i = 0; i < bound && !done; i++) begin
            @(negedge clk);
            if (!busy) done = 1'b1;
        end
        check_eq("idle_wait", busy, 0);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        bus_q.delete();
        snap_q.delete();
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        int sc, t1, t2, t3, tmp;

        // Reset values
        repeat (3) @(negedge clk);
        check_eq("rst_write_n", write_n, 1);
        check_eq("rst_cs", chipselect, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_tcount", timeout_count, 0);
        check_eq("rst_snap", snap_value, 0);
        check_eq("rst_wdog", wdog_err, 0);
        reset_n = 1'b1;

        // Single shot, large period, interrupt forced by the model
        push_prog(32'h0001_86A0, 1'b0);
        do_cmd(1'b1, 1'b0, 32'h0001_86A0, 1'b0, sc);
        check_eq("t1_first_cs", {chipselect, write_n, address}, {1'b1, 1'b0, 3'd1});
        repeat (6) @(negedge clk);
        check_eq("t1_ctrl_lat", ctrl_cyc - sc, 4);
        irq_kick(1'b1);
        wait_snap(50, tmp);
        wait_idle(20);
        check_eq("t1_halt_at_snap", w8_cyc, snap_cyc);
        check_eq("t1_tcount", timeout_count, 1);
        check_eq("t1_q", bus_q.size(), 0);

        // Continuous mode, three natural timeouts, then stop in WAIT_IRQ
        reset_dut();
        push_prog(32'd100, 1'b1);
        do_cmd(1'b1, 1'b0, 32'd100, 1'b1, sc);
        wait_snap(300, t1);
        wait_snap(300, t2);
        wait_snap(300, t3);
        check_eq("t2_space1", t2 - t1, 101);
        check_eq("t2_space2", t3 - t2, 101);
        check_eq("t2_tcount", timeout_count, 3);
        check_eq("t2_busy", busy, 1);
        bus_q.push_back(bw(3'd1, 16'h0008));
        do_cmd(1'b0, 1'b1, 32'd0, 1'b0, sc);
        check_eq("t2_stop_halt", {chipselect, write_n, address, writedata},
                 {1'b1, 1'b0, 3'd1, 16'h0008});
        wait_idle(10);
        check_eq("t2_q", bus_q.size(), 0);

        // Rejected period and simultaneous start/stop
        do_cmd(1'b1, 1'b0, 32'd1, 1'b0, sc);
        check_eq("t3_cmd_err", cmd_err, 1);
        check_eq("t3_busy", busy, 0);
        @(negedge clk);
        check_eq("t3_cmd_err_pulse", cmd_err, 0);
        do_cmd(1'b1, 1'b1, 32'd100, 1'b0, sc);
        check_eq("t3_both_busy", busy, 0);
        check_eq("t3_both_err", cmd_err, 0);
        repeat (5) @(negedge clk);
        check_eq("t3_still_idle", busy, 0);

        // Watchdog: period 20 + WDOG_MAX 10, no interrupt
        m_mute = 1'b1;
        push_prog(32'd20, 1'b0);
        bus_q.push_back(bw(3'd1, 16'h0008));
        do_cmd(1'b1, 1'b0, 32'd20, 1'b0, sc);
        repeat (33) @(negedge clk);
        check_eq("t4_wdog_early", wdog_err, 0);
        @(negedge clk);
        check_eq("t4_wdog_set", wdog_err, 1);
        check_eq("t4_wdog_halt", {chipselect, write_n, address, writedata},
                 {1'b1, 1'b0, 3'd1, 16'h0008});
        wait_idle(10);
        check_eq("t4_wdog_sticky", wdog_err, 1);

        // Next start clears wdog_err; stop during W_PL defers to first WAIT_IRQ
        push_prog(32'd100, 1'b1);
        bus_q.push_back(bw(3'd1, 16'h0008));
        do_cmd(1'b1, 1'b0, 32'd100, 1'b1, sc);
        check_eq("t5_wdog_clr", wdog_err, 0);
        do_cmd(1'b0, 1'b1, 32'd0, 1'b0, tmp);
        repeat (3) @(negedge clk);
        check_eq("t5_ctrl_done", ctrl_cyc - sc, 4);
        check_eq("t5_halt", {chipselect, write_n, address, writedata},
                 {1'b1, 1'b0, 3'd1, 16'h0008});
        wait_idle(10);
        check_eq("t5_q", bus_q.size(), 0);
        m_mute = 1'b0;

        // Reset in the middle of the snapshot read
        push_prog(32'h0001_86A0, 1'b1);
        do_cmd(1'b1, 1'b0, 32'h0001_86A0, 1'b1, sc);
        repeat (6) @(negedge clk);
        irq_kick(1'b0);
        begin
            bit hit;
            hit = 1'b0;
            for (int i = 0; i < 20 && !hit; i++) begin
                @(negedge clk);
                if (chipselect && write_n && address == 3'd4) hit = 1'b1;
            end
            check_eq("t6_reach_rsl", hit, 1);
        end
        #2 reset_n = 1'b0;
        #1;
        check_eq("t6_cs", chipselect, 0);
        check_eq("t6_write_n", write_n, 1);
        check_eq("t6_busy", busy, 0);
        check_eq("t6_tcount", timeout_count, 0);
        check_eq("t6_snap", snap_value, 0);
        @(negedge clk);
        reset_n = 1'b1;
        m_mute = 1'b1;
        bus_q.delete();
        snap_q.delete();
        repeat (5) @(negedge clk);
        check_eq("t6_quiet", busy, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/timer_seq_master.md
Name: timer_seq_master

Overview:
- Avalon-MM master that drives the 16-bit interval-timer register interface (3-bit word address) from the slave's far side.
- Programs the period and control registers and arms the timer.
- Services each timeout interrupt by clearing status, taking a counter snapshot and reading it back.
- Sits between PWM/control logic and the system timer, so no CPU software is needed to run periodic timing.

Parameters:
- MIN_PERIOD, 2: smallest accepted cmd_period; smaller values are rejected.
- WDOG_MAX, 32'hFFFF_FFFF: cycles allowed in WAIT_IRQ beyond the programmed period before wdog_err is raised.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- cmd_start  in  1  one-cycle pulse: program the timer and start it
- cmd_stop  in  1  one-cycle pulse: stop the timer
- cmd_period  in  32  timer period; sampled with cmd_start
- cmd_continuous  in  1  continuous mode; sampled with cmd_start
- busy  out  1  high in any state except IDLE
- cmd_err  out  1  one-cycle pulse when cmd_start is rejected
- snap_valid  out  1  one-cycle pulse when snap_value is updated
- snap_value  out  32  last snapshot read from the timer
- timeout_count  out  16  number of timeouts serviced; wraps
- wdog_err  out  1  sticky; cleared by the next accepted cmd_start
- address  out  3  timer word address
- chipselect  out  1  access strobe
- write_n  out  1  low = write; high with chipselect = read
- writedata  out  16  write data
- readdata  in  16  timer read data; registered by the slave, valid one cycle after the address
- irq  in  1  timer interrupt, level

Behaviour:
Interface:
- One clock; reset is asynchronous and active-low.
- Clock port: clk. Reset port: reset_n.

Reset values:
- All outputs 0, except write_n = 1.
- State = IDLE. Latches cleared.

Bus rules:
- Every access lasts exactly one cycle, with no wait states.
- chipselect is high only in bus states.
- write_n is low only in write states.
- Reads capture readdata in the cycle after the address is presented.

States and transitions:
- IDLE: on cmd_start with cmd_period < MIN_PERIOD, pulse cmd_err and stay in IDLE. On a valid cmd_start, latch period and continuous, clear wdog_err, go to W_STOP. If cmd_start and cmd_stop arrive together, stop wins: no action. cmd_start while busy is ignored.
- W_STOP: write addr1 = 16'h0008.
- W_PL: write addr2 = period[15:0].
- W_PH: write addr3 = period[31:16].
- W_CTRL: write addr1 = {12'h0, 1'b0, 1'b1, cont, 1'b1}, i.e. start with interrupt enabled. Clear the watchdog counter. Go to WAIT_IRQ.
- WAIT_IRQ: the watchdog counter increments each cycle.
  - If stop_pend is set or cmd_stop arrives, go to W_HALT.
  - Else if irq = 1, go to W_CLR.
  - Else if the counter equals period + WDOG_MAX, saturating at 2^32-1, set wdog_err and go to W_HALT.
- W_CLR: write addr0 = 0, clearing the timeout flag. Increment timeout_count, mod 2^16.
- W_SNAP: write addr4 = 0, which latches the snapshot.
- R_SL: read addr4.
- R_SH: read addr5; capture snap_value[15:0].
- CAP: capture snap_value[31:16]; pulse snap_valid.
  - If cont = 1 and no stop is pending, go to WAIT_IRQ and clear the watchdog counter.
  - Otherwise go to W_HALT.
- W_HALT: write addr1 = 16'h0008; clear stop_pend; go to IDLE.

Stop handling:
- cmd_stop arriving in any busy state other than WAIT_IRQ sets stop_pend.
- The current sequence completes; the halt is taken at the next WAIT_IRQ or CAP.

Latency and interrupt sampling:
- Valid cmd_start to the first W_STOP cycle: 1 cycle.
- Timer armed at the end of the W_CTRL cycle, 4 cycles after the command.
- irq sampled high to snap_valid: 6 cycles.
- irq is not sampled again until the CAP decision. This covers the slave's registered deassertion after the status clear.

Reset:
- Reset asserted mid-operation returns to IDLE immediately with no further bus cycles.
- The timer keeps its own state, since it has its own reset.

Test Plan:
- Reset -> write_n = 1, chipselect = 0, busy = 0, timeout_count = 0, snap_value = 0.
- cmd_start, period = 32'h0001_86A0, cont = 0 -> writes in consecutive cycles: (1, 0008), (2, 86A0), (3, 0001), (1, 0005). Then irq -> writes (0, 0000) and (4, 0000), then reads of addr4 and addr5. snap_valid fires with the model snapshot, then write (1, 0008); busy drops.
- cont = 1, period = 100, run 3 irqs -> timeout_count = 3; three snap_valid pulses spaced about 101 cycles apart; no W_HALT until cmd_stop; cmd_stop in WAIT_IRQ -> write (1, 0008) the next cycle.
- cmd_period = 1 -> cmd_err pulse, no bus activity, busy stays 0. Simultaneous cmd_start and cmd_stop in IDLE -> nothing happens.
- WDOG_MAX = 10, period = 20, irq held low -> wdog_err set 30 cycles after entering WAIT_IRQ, followed by a halt write. The next valid cmd_start clears wdog_err.
- cmd_stop during W_PL with cont = 1 -> programming completes, then W_HALT on the first WAIT_IRQ cycle. Reset asserted during R_SL -> chipselect drops immediately and outputs return to reset values.
